// File: rtl/cgra_rf_pkg.sv
// Shared helpers for the CGRA rotating register file: depth derivation,
// packed-bus slice offsets and logical-to-physical address mapping.
package cgra_rf_pkg;

  function automatic int depth_of(input int log2regs);
    return 1 << log2regs;
  endfunction

  function automatic int addr_slice(input int port, input int log2regs);
    return port * log2regs;
  endfunction

  function automatic int data_slice(input int port, input int size);
    return port * size;
  endfunction

  // Masking with DEPTH-1 gives the natural LOG2REGS-bit wrap.
  function automatic int phys_addr(input int logical, input int base, input int log2regs);
    return (logical + base) & (depth_of(log2regs) - 1);
  endfunction

endpackage

// File: rtl/rf_write_merge.sv
// Resolves all write ports against one physical entry: hit flag, winning data
// (highest enabled port index) and a collision flag when two or more ports hit.
module rf_write_merge
  import cgra_rf_pkg::*;
#(
  parameter int LOG2REGS = 3,
  parameter int SIZE     = 32,
  parameter int NUM_IN   = 4
) (
  input  logic [NUM_IN-1:0]          we_i,
  input  logic [NUM_IN*LOG2REGS-1:0] phys_i,
  input  logic [NUM_IN*SIZE-1:0]     data_i,
  input  logic [LOG2REGS-1:0]        idx_i,
  output logic                       hit_o,
  output logic [SIZE-1:0]            data_o,
  output logic                       collision_o
);

  always_comb begin
    hit_o       = 1'b0;
    data_o      = '0;
    collision_o = 1'b0;
    // Ascending scan so a later (higher-index) hit overwrites the data.
    for (int k = 0; k < NUM_IN; k++) begin
      if (we_i[k] && (phys_i[addr_slice(k, LOG2REGS) +: LOG2REGS] == idx_i)) begin
        collision_o = collision_o | hit_o;
        hit_o       = 1'b1;
        data_o      = data_i[data_slice(k, SIZE) +: SIZE];
      end
    end
  end

endmodule

// File: rtl/rotating_register_file.sv
// Parametrised multi-port register file for CGRA PEs with rotating base,
// write-conflict priority/flag, optional write-to-read bypass and sync clear.
module rotating_register_file
  import cgra_rf_pkg::*;
#(
  parameter int LOG2REGS = 3,
  parameter int SIZE     = 32,
  parameter int NUM_IN   = 4,
  parameter int NUM_OUT  = 8,
  parameter int BYPASS   = 1,
  parameter int ROTATE   = 1
) (
  input  logic                        CGRA_Clock,
  input  logic                        CGRA_Reset,
  input  logic [NUM_IN-1:0]           WE,
  input  logic [NUM_IN*LOG2REGS-1:0]  address_in,
  input  logic [NUM_IN*SIZE-1:0]      in,
  input  logic [NUM_OUT-1:0]          RE,
  input  logic [NUM_OUT*LOG2REGS-1:0] address_out,
  output logic [NUM_OUT*SIZE-1:0]     out,
  input  logic                        rotate,
  input  logic                        clear,
  output logic [LOG2REGS-1:0]         base,
  output logic                        wr_conflict
);

  localparam int DEPTH = depth_of(LOG2REGS);

  logic [SIZE-1:0]             entry_q [DEPTH];
  logic [SIZE-1:0]             entry_d [DEPTH];
  logic [NUM_OUT*SIZE-1:0]     out_q, out_d;
  logic [LOG2REGS-1:0]         base_q, base_d;
  logic                        conflict_q, conflict_d;

  logic [NUM_IN*LOG2REGS-1:0]  wr_phys;
  logic [NUM_OUT*LOG2REGS-1:0] rd_phys;
  logic [DEPTH-1:0]            ent_hit;
  logic [DEPTH-1:0]            ent_coll;
  logic [SIZE-1:0]             ent_data [DEPTH];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_wr_map
    assign wr_phys[addr_slice(k, LOG2REGS) +: LOG2REGS] = LOG2REGS'(phys_addr(
        32'(address_in[addr_slice(k, LOG2REGS) +: LOG2REGS]), 32'(base_q), LOG2REGS));
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_rd_map
    assign rd_phys[addr_slice(j, LOG2REGS) +: LOG2REGS] = LOG2REGS'(phys_addr(
        32'(address_out[addr_slice(j, LOG2REGS) +: LOG2REGS]), 32'(base_q), LOG2REGS));
  end

  // One merge per entry; its result also serves the bypass path of any read hitting that entry.
  for (genvar e = 0; e < DEPTH; e++) begin : g_merge
    rf_write_merge #(
      .LOG2REGS (LOG2REGS),
      .SIZE     (SIZE),
      .NUM_IN   (NUM_IN)
    ) u_merge (
      .we_i        (WE),
      .phys_i      (wr_phys),
      .data_i      (in),
      .idx_i       (LOG2REGS'(e)),
      .hit_o       (ent_hit[e]),
      .data_o      (ent_data[e]),
      .collision_o (ent_coll[e])
    );
  end

  always_comb begin
    entry_d    = entry_q;
    out_d      = out_q;
    base_d     = base_q;
    conflict_d = |ent_coll;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_hit[e]) entry_d[e] = ent_data[e];
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (RE[j]) begin
        if ((BYPASS != 0) && ent_hit[rd_phys[addr_slice(j, LOG2REGS) +: LOG2REGS]])
          out_d[data_slice(j, SIZE) +: SIZE] = ent_data[rd_phys[addr_slice(j, LOG2REGS) +: LOG2REGS]];
        else
          out_d[data_slice(j, SIZE) +: SIZE] = entry_q[rd_phys[addr_slice(j, LOG2REGS) +: LOG2REGS]];
      end
    end
    if ((ROTATE != 0) && rotate) base_d = base_q - 1'b1;
    if (clear) begin
      entry_d    = '{default: '0};
      out_d      = '0;
      base_d     = '0;
      conflict_d = 1'b0;
    end
  end

  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
    if (!CGRA_Reset) begin
      entry_q    <= '{default: '0};
      out_q      <= '0;
      base_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      out_q      <= out_d;
      base_q     <= base_d;
      conflict_q <= conflict_d;
    end
  end

  assign out         = out_q;
  assign base        = base_q;
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_rotating_register_file.sv
// Directed self-checking bench: one bypassing and one non-bypassing instance
// share all inputs and are compared against hand-computed values.
module tb_rotating_register_file;

  logic         clock;
  logic         resetN;
  logic [3:0]   we;
  logic [11:0]  addrIn;
  logic [127:0] dataIn;
  logic [7:0]   re;
  logic [23:0]  addrOut;
  logic [255:0] outB, outN;
  logic         rotate, clear;
  logic [2:0]   baseB, baseN;
  logic         conflictB, conflictN;

  int checkCount = 0;
  int failCount  = 0;

  rotating_register_file #(.BYPASS(1)) dutB (
    .CGRA_Clock(clock), .CGRA_Reset(resetN), .WE(we), .address_in(addrIn), .in(dataIn),
    .RE(re), .address_out(addrOut), .out(outB), .rotate(rotate), .clear(clear),
    .base(baseB), .wr_conflict(conflictB)
  );

  rotating_register_file #(.BYPASS(0)) dutN (
    .CGRA_Clock(clock), .CGRA_Reset(resetN), .WE(we), .address_in(addrIn), .in(dataIn),
    .RE(re), .address_out(addrOut), .out(outN), .rotate(rotate), .clear(clear),
    .base(baseN), .wr_conflict(conflictN)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    we     = '0;
    re     = '0;
    rotate = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic setWrite(input int k, input logic [2:0] a, input logic [31:0] d);
    we[k]             = 1'b1;
    addrIn[k*3 +: 3]  = a;
    dataIn[k*32 +: 32] = d;
  endtask

  task automatic setRead(input int j, input logic [2:0] a);
    re[j]             = 1'b1;
    addrOut[j*3 +: 3] = a;
  endtask

  initial begin
    resetN  = 1'b0;
    addrIn  = '0;
    dataIn  = '0;
    addrOut = '0;
    idleInputs();
    #12;
    checkOutput("rst_out0", outB[31:0], 32'h0);
    checkOutput("rst_out7", outB[255:224], 32'h0);
    checkOutput("rst_base", 32'(baseB), 32'h0);
    checkOutput("rst_conflict", 32'(conflictB), 32'h0);
    resetN = 1'b1;

    // Basic write then read
    setWrite(0, 3'd3, 32'hDEADBEEF);
    applyStimulus();
    idleInputs();
    setRead(5, 3'd3);
    applyStimulus();
    checkOutput("t1_out5_byp", outB[5*32 +: 32], 32'hDEADBEEF);
    checkOutput("t1_out5_nobyp", outN[5*32 +: 32], 32'hDEADBEEF);
    checkOutput("t1_out0", outB[31:0], 32'h0);
    checkOutput("t1_out4", outB[4*32 +: 32], 32'h0);

    // Three-way write collision on address 6
    idleInputs();
    setWrite(0, 3'd6, 32'h11);
    setWrite(2, 3'd6, 32'h22);
    setWrite(3, 3'd6, 32'h33);
    applyStimulus();
    checkOutput("t2_conflict_set", 32'(conflictB), 32'h1);
    idleInputs();
    setWrite(1, 3'd0, 32'h55);
    setRead(0, 3'd6);
    applyStimulus();
    checkOutput("t2_conflict_clr", 32'(conflictB), 32'h0);
    checkOutput("t2_entry6", outB[31:0], 32'h33);

    // Bypass versus stored-value read
    idleInputs();
    setWrite(0, 3'd2, 32'hA5A5A5A5);
    setRead(1, 3'd2);
    applyStimulus();
    checkOutput("t3_byp_same", outB[1*32 +: 32], 32'hA5A5A5A5);
    checkOutput("t3_nobyp_same", outN[1*32 +: 32], 32'h0);
    idleInputs();
    setRead(1, 3'd2);
    applyStimulus();
    checkOutput("t3_nobyp_reread", outN[1*32 +: 32], 32'hA5A5A5A5);

    // Rotate together with a write: write lands at old base
    idleInputs();
    setWrite(0, 3'd0, 32'h7);
    rotate = 1'b1;
    applyStimulus();
    checkOutput("t4_base_wrap", 32'(baseB), 32'h7);
    idleInputs();
    setRead(2, 3'd1);
    setRead(3, 3'd0);
    applyStimulus();
    checkOutput("t4_logical1", outB[2*32 +: 32], 32'h7);
    checkOutput("t4_logical0", outB[3*32 +: 32], 32'h0);
    idleInputs();
    rotate = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("t4_base_mid", 32'(baseB), 32'h3);
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("t4_base_back0", 32'(baseB), 32'h0);
    checkOutput("t4_base_nobyp", 32'(baseN), 32'h0);

    // Disabled read port holds its value
    idleInputs();
    setRead(4, 3'd2);
    applyStimulus();
    checkOutput("t5_out4_load", outB[4*32 +: 32], 32'hA5A5A5A5);
    idleInputs();
    setWrite(0, 3'd2, 32'h12345678);
    applyStimulus();
    checkOutput("t5_out4_hold_byp", outB[4*32 +: 32], 32'hA5A5A5A5);
    checkOutput("t5_out4_hold_nobyp", outN[4*32 +: 32], 32'hA5A5A5A5);

    // Clear beats write, read and rotate
    idleInputs();
    rotate = 1'b1;
    applyStimulus();
    checkOutput("t5_base_pre_clear", 32'(baseB), 32'h7);
    idleInputs();
    clear = 1'b1;
    rotate = 1'b1;
    setWrite(0, 3'd1, 32'hFFFF);
    setRead(6, 3'd2);
    applyStimulus();
    checkOutput("t5_clr_out4", outB[4*32 +: 32], 32'h0);
    checkOutput("t5_clr_out5", outB[5*32 +: 32], 32'h0);
    checkOutput("t5_clr_out6", outB[6*32 +: 32], 32'h0);
    checkOutput("t5_clr_base", 32'(baseB), 32'h0);
    idleInputs();
    setRead(0, 3'd1);
    setRead(1, 3'd3);
    applyStimulus();
    checkOutput("t5_clr_entry1", outB[31:0], 32'h0);
    checkOutput("t5_clr_entry3", outB[1*32 +: 32], 32'h0);

    // Asynchronous reset mid-operation
    idleInputs();
    setWrite(0, 3'd5, 32'hCAFE);
    setWrite(1, 3'd5, 32'hBEEF);
    setRead(0, 3'd5);
    rotate = 1'b1;
    applyStimulus();
    checkOutput("t6_conflict", 32'(conflictB), 32'h1);
    checkOutput("t6_base", 32'(baseB), 32'h7);
    checkOutput("t6_byp_winner", outB[31:0], 32'hBEEF);
    idleInputs();
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("t6_async_out0", outB[31:0], 32'h0);
    checkOutput("t6_async_base", 32'(baseB), 32'h0);
    checkOutput("t6_async_conflict", 32'(conflictB), 32'h0);
    #3;
    resetN = 1'b1;
    setRead(0, 3'd5);
    applyStimulus();
    checkOutput("t6_entry5_zero", outB[31:0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
